seq_match_logger: RTL

SEQ_MATCH_LOGGER -- requirements
Module: seq_match_logger

---
 rtl/seq_pkg.sv | 18 +
 rtl/seq_match_logger_if.sv | 18 +
 rtl/seq_rec_fifo.sv | 81 ++++++++
 rtl/seq_match_logger.sv | 80 ++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared defaults and occupancy-state encoding for the match logger
// Purpose: parameter defaults (timestamp, buffer depth, counter widths) and the
//          one-hot buffer occupancy state used by seq_rec_fifo.
// Ports:   none (package).
package seq_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // One-hot, in the same style as the upstream detector states.
  typedef enum logic [2:0] {
    OCC_EMPTY   = 3'b001,
    OCC_PARTIAL = 3'b010,
    OCC_FULL    = 3'b100
  } occ_state_e;

endpackage

// File: rtl/seq_match_logger_if.sv
// rtl/seq_match_logger_if.sv - record output handshake between logger and consumer
// Purpose: groups the match-record stream (valid/ready/timestamp).
// Ports:   m_valid (head holds a record), m_ready (consumer accepts head),
//          m_ts (head timestamp). master = logger side, slave = consumer side.
interface seq_match_logger_if
  import seq_pkg::*;
#(
  parameter int TS_W = TS_W_DEF
);

  logic            m_valid;
  logic            m_ready;
  logic [TS_W-1:0] m_ts;

  modport master (output m_valid, output m_ts, input m_ready);
  modport slave  (input m_valid, input m_ts, output m_ready);

endinterface

// File: rtl/seq_rec_fifo.sv
// rtl/seq_rec_fifo.sv - circular record buffer with occupancy state and level
// Purpose: FIFO storage for match timestamps; push is refused only when full
//          and no pop happens on the same edge.
// Ports:   clk, rst (async active-low), push/din (write request/data),
//          pop (read request, ignored when empty), dout (head, 0 when empty),
//          empty, full, level (occupancy 0..DEPTH).
module seq_rec_fifo
  import seq_pkg::*;
#(
  parameter int W     = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  occ_state_e    state;
  occ_state_e    next_state;
  logic [LW-1:0] next_level;
  logic          do_push;
  logic          do_pop;

  assign empty = (state == OCC_EMPTY);
  assign full  = (state == OCC_FULL);

  // A pop frees the slot on the same edge, so a full buffer still accepts.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = empty ? '0 : mem[rd_ptr];

  always_comb begin
    next_level = level;
    next_state = state;
    case ({do_push, do_pop})
      2'b10:   next_level = level + LW'(1);
      2'b01:   next_level = level - LW'(1);
      default: next_level = level;
    endcase
    if (next_level == '0)
      next_state = OCC_EMPTY;
    else if (next_level == LW'(DEPTH))
      next_state = OCC_FULL;
    else
      next_state = OCC_PARTIAL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= OCC_EMPTY;
      level  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= next_state;
      level <= next_level;
      // DEPTH is a power of two, so the pointers wrap on natural overflow.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage needs no reset: dout is masked to 0 while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/seq_match_logger.sv
// rtl/seq_match_logger.sv - timestamps match pulses into a record buffer with stats
// Purpose: free-running cycle timestamp; each pattern pulse logs the timestamp,
//          counts the match, and counts a drop when the buffer cannot take it.
// Ports:   clk, rst (async active-low), pattern (match pulse), clr (sync clear
//          of counters/ovf), m (record stream, master), match_cnt, drop_cnt
//          (saturating), ovf (sticky drop flag), level (buffer occupancy).
module seq_match_logger
  import seq_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pattern,
  input  logic                    clr,
  seq_match_logger_if.master      m,
  output logic [CNT_W-1:0]        match_cnt,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic                    ovf,
  output logic [$clog2(DEPTH):0]  level
);

  logic [TS_W-1:0]  ts_cnt;
  logic             empty;
  logic             full;
  logic             pop;
  logic             drop;
  logic [CNT_W-1:0] match_base;
  logic [CNT_W-1:0] drop_base;
  logic [CNT_W-1:0] match_nxt;
  logic [CNT_W-1:0] drop_nxt;
  logic             ovf_nxt;

  seq_rec_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pattern),
    .din   (ts_cnt),
    .pop   (pop),
    .dout  (m.m_ts),
    .empty (empty),
    .full  (full),
    .level (level)
  );

  assign m.m_valid = !empty;
  assign pop       = m.m_valid && m.m_ready;
  assign drop      = pattern && full && !pop;

  // clr wins over the old value, but a pulse on the same edge still counts.
  always_comb begin
    match_base = clr ? '0 : match_cnt;
    drop_base  = clr ? '0 : drop_cnt;
    match_nxt  = match_base;
    drop_nxt   = drop_base;
    if (pattern && (match_base != '1)) match_nxt = match_base + CNT_W'(1);
    if (drop && (drop_base != '1))     drop_nxt  = drop_base + CNT_W'(1);
    ovf_nxt = (clr ? 1'b0 : ovf) | drop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_cnt    <= '0;
      match_cnt <= '0;
      drop_cnt  <= '0;
      ovf       <= 1'b0;
    end else begin
      ts_cnt    <= ts_cnt + TS_W'(1);
      match_cnt <= match_nxt;
      drop_cnt  <= drop_nxt;
      ovf       <= ovf_nxt;
    end
  end

endmodule
